// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register/word widths, hazard FSM states and the pipeline
// control bundle driven by hazard_unit.
package cpu_types_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned WORD_W = 32;

  typedef logic [REG_W-1:0]  regbits_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } hazard_state_t;

  // Pipeline control bundle; a set flush overrides the enable of the same register.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_en;
  } hazard_ctrl_t;

  // Field order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en
  localparam hazard_ctrl_t CTRL_FREEZE   = 7'b000_0000;
  localparam hazard_ctrl_t CTRL_RUN      = 7'b110_1011;
  localparam hazard_ctrl_t CTRL_SQUASH   = 7'b111_1111;
  localparam hazard_ctrl_t CTRL_LOAD_USE = 7'b000_1111;
  localparam hazard_ctrl_t CTRL_IMISS    = 7'b011_1011;
  localparam hazard_ctrl_t CTRL_DRAIN    = 7'b001_0111;
  localparam hazard_ctrl_t CTRL_RESET    = 7'b001_0100;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: flags an ID-stage read of the register a load
// in EX is about to write.
//   memtoReg_EX, RegWr_EX, wsel_EX : EX-stage load / write / destination
//   rs_ID, rt_ID, uses_rt_ID       : ID-stage sources and rt-use flag
//   lu_hazard                      : one bubble required
module load_use_detect
  import cpu_types_pkg::*;
(
  input  logic     memtoReg_EX,
  input  logic     RegWr_EX,
  input  regbits_t wsel_EX,
  input  regbits_t rs_ID,
  input  regbits_t rt_ID,
  input  logic     uses_rt_ID,
  output logic     lu_hazard
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (wsel_EX == rs_ID);
  assign rt_match = uses_rt_ID & (wsel_EX == rt_ID);

  // $0 is hardwired, so a load targeting it never creates a dependency.
  assign lu_hazard = memtoReg_EX & RegWr_EX & (wsel_EX != '0) & (rs_match | rt_match);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline sequencing controller for the 5-stage core. Produces PC and
// pipeline-register enable/flush controls (Mealy, same-cycle), a registered
// halt flag and a saturating stall-cycle counter.
//   CLK, nRST                 : clock, synchronous active-low reset
//   ihit, dhit                : instruction fetch / data access completed
//   dREN_MEM, dWEN_MEM        : MEM-stage data access in flight
//   memtoReg_EX, RegWr_EX,
//   wsel_EX, rs_ID, rt_ID,
//   uses_rt_ID                : load-use comparator inputs
//   branch_taken_EX, halt_EX  : PC redirect / halt in EX
//   pc_en, ifid_*, idex_*,
//   exmem_en, memwb_en        : pipeline controls
//   halt, stall_cycles        : core halted, stalled-cycle count
module hazard_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic     CLK,
  input  logic     nRST,
  input  logic     ihit,
  input  logic     dhit,
  input  logic     dREN_MEM,
  input  logic     dWEN_MEM,
  input  logic     memtoReg_EX,
  input  logic     RegWr_EX,
  input  regbits_t wsel_EX,
  input  regbits_t rs_ID,
  input  regbits_t rt_ID,
  input  logic     uses_rt_ID,
  input  logic     branch_taken_EX,
  input  logic     halt_EX,
  output logic     pc_en,
  output logic     ifid_en,
  output logic     ifid_flush,
  output logic     idex_en,
  output logic     idex_flush,
  output logic     exmem_en,
  output logic     memwb_en,
  output logic     halt,
  output word_t    stall_cycles
);

  localparam int unsigned DRAIN_W   = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam word_t       STALL_MAX = '1;

  hazard_state_t      state_q, state_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  word_t              stall_cycles_q, stall_cycles_d;
  logic               halt_q, halt_d;

  logic         lu_hazard;
  logic         dmiss;
  logic         freeze;
  logic         run_state;
  hazard_ctrl_t ctrl;

  load_use_detect u_load_use_detect (
    .memtoReg_EX (memtoReg_EX),
    .RegWr_EX    (RegWr_EX),
    .wsel_EX     (wsel_EX),
    .rs_ID       (rs_ID),
    .rt_ID       (rt_ID),
    .uses_rt_ID  (uses_rt_ID),
    .lu_hazard   (lu_hazard)
  );

  assign dmiss     = (dREN_MEM | dWEN_MEM) & ~dhit;
  assign run_state = (state_q == RUN) || (state_q == MEM_WAIT);
  // Once waiting, the access is known outstanding; only dhit releases the freeze.
  assign freeze    = (state_q == MEM_WAIT) ? ~dhit : dmiss;

  // State register, drain counter, stall counter and halt flag.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q        <= RUN;
      drain_cnt_q    <= '0;
      stall_cycles_q <= '0;
      halt_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      drain_cnt_q    <= drain_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      halt_q         <= halt_d;
    end
  end

  // Next-state and drain counter.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      RUN, MEM_WAIT: begin
        if (freeze) begin
          state_d = MEM_WAIT;
        end else if (halt_EX) begin
          state_d     = DRAIN;
          drain_cnt_d = DRAIN_W'(DRAIN_CYCLES);
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (!dmiss) begin
          if (drain_cnt_q <= DRAIN_W'(1)) begin
            state_d     = HALTED;
            drain_cnt_d = '0;
          end else begin
            drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
          end
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // Mealy control outputs; reset forces bubbles into IF/ID and ID/EX.
  always_comb begin
    ctrl = CTRL_FREEZE;
    if (!nRST) begin
      ctrl = CTRL_RESET;
    end else begin
      case (state_q)
        RUN, MEM_WAIT: begin
          if (freeze)               ctrl = CTRL_FREEZE;
          else if (halt_EX)         ctrl = CTRL_DRAIN;
          else if (branch_taken_EX) ctrl = CTRL_SQUASH;
          else if (lu_hazard)       ctrl = CTRL_LOAD_USE;
          else if (!ihit)           ctrl = CTRL_IMISS;
          else                      ctrl = CTRL_RUN;
        end
        DRAIN: begin
          if (!dmiss) ctrl = CTRL_DRAIN;
        end
        default: ctrl = CTRL_FREEZE;
      endcase
    end
  end

  // Stall counter counts held-PC cycles only while the core is running.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    halt_d         = (state_d == HALTED);
    if (!ctrl.pc_en && run_state && (stall_cycles_q != STALL_MAX)) begin
      stall_cycles_d = stall_cycles_q + WORD_W'(1);
    end
  end

  assign pc_en        = ctrl.pc_en;
  assign ifid_en      = ctrl.ifid_en;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_en      = ctrl.idex_en;
  assign idex_flush   = ctrl.idex_flush;
  assign exmem_en     = ctrl.exmem_en;
  assign memwb_en     = ctrl.memwb_en;
  assign halt         = halt_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: table of single-cycle vectors,
// hand-written multi-cycle sequences, and random stimulus against a
// behavioural model.
module tb_hazard_unit;

  localparam int DRAIN = 2;

  logic        CLK, nRST;
  logic        ihit, dhit, dREN_MEM, dWEN_MEM, memtoReg_EX, RegWr_EX;
  logic [4:0]  wsel_EX, rs_ID, rt_ID;
  logic        uses_rt_ID, branch_taken_EX, halt_EX;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halt;
  logic [31:0] stall_cycles;

  hazard_unit #(.DRAIN_CYCLES(DRAIN)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .dREN_MEM(dREN_MEM), .dWEN_MEM(dWEN_MEM),
    .memtoReg_EX(memtoReg_EX), .RegWr_EX(RegWr_EX), .wsel_EX(wsel_EX),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rt_ID(uses_rt_ID),
    .branch_taken_EX(branch_taken_EX), .halt_EX(halt_EX),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .halt(halt), .stall_cycles(stall_cycles)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en
  logic [6:0] act_ctrl;
  assign act_ctrl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en};

  localparam logic [6:0] E_FRZ  = 7'b0000000;
  localparam logic [6:0] E_RUN  = 7'b1101011;
  localparam logic [6:0] E_SQ   = 7'b1111111;
  localparam logic [6:0] E_LU   = 7'b0001111;
  localparam logic [6:0] C_LU   = 7'b1110111;  // idex_en irrelevant under flush
  localparam logic [6:0] E_IM   = 7'b0111011;
  localparam logic [6:0] C_IM   = 7'b1011111;  // ifid_en irrelevant under flush
  localparam logic [6:0] E_DR   = 7'b0010111;
  localparam logic [6:0] C_DR   = 7'b1011011;
  localparam logic [6:0] E_RST  = 7'b0010100;
  localparam logic [6:0] C_ALL  = 7'h7F;

  typedef struct {
    logic       rst_n, ihit, dhit, dren, dwen, m2r, rwr;
    logic [4:0] wsel, rs, rt;
    logic       uses_rt, br, hlt;
  } vin_t;

  typedef struct {
    string      name;
    vin_t       in;
    logic [6:0] exp;
    logic [6:0] care;
  } tvec_t;

  tvec_t tbl[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: a few flags describing where the core is.
  bit      m_wait, m_halted;
  int      m_drain_left;
  longint  m_stall;

  function automatic vin_t idle();
    vin_t v;
    v = '{rst_n:1'b1, ihit:1'b1, dhit:1'b0, dren:1'b0, dwen:1'b0, m2r:1'b0, rwr:1'b0,
          wsel:5'd0, rs:5'd0, rt:5'd0, uses_rt:1'b0, br:1'b0, hlt:1'b0};
    return v;
  endfunction

  function automatic bit m_dmiss(input vin_t v);
    return (v.dren || v.dwen) && !v.dhit;
  endfunction

  function automatic bit m_load_use(input vin_t v);
    if (!(v.m2r && v.rwr) || v.wsel == 5'd0) return 1'b0;
    return (v.wsel == v.rs) || (v.uses_rt && v.wsel == v.rt);
  endfunction

  task automatic model_out(input vin_t v, output logic [6:0] e, output logic [6:0] care);
    bit frz;
    care = C_ALL;
    frz  = m_wait ? !v.dhit : m_dmiss(v);
    if (!v.rst_n)                 e = E_RST;
    else if (m_halted)            e = E_FRZ;
    else if (m_drain_left > 0) begin
      if (m_dmiss(v)) e = E_FRZ;
      else begin e = E_DR; care = C_DR; end
    end
    else if (frz)                 e = E_FRZ;
    else if (v.hlt)          begin e = E_DR; care = C_DR; end
    else if (v.br)                e = E_SQ;
    else if (m_load_use(v))  begin e = E_LU; care = C_LU; end
    else if (!v.ihit)        begin e = E_IM; care = C_IM; end
    else                          e = E_RUN;
  endtask

  task automatic model_update(input vin_t v, input logic [6:0] e);
    bit frz;
    frz = m_wait ? !v.dhit : m_dmiss(v);
    if (!v.rst_n) begin
      m_wait = 0; m_halted = 0; m_drain_left = 0; m_stall = 0;
    end else if (m_halted) begin
      m_halted = 1;
    end else if (m_drain_left > 0) begin
      if (!m_dmiss(v)) begin
        m_drain_left--;
        if (m_drain_left == 0) m_halted = 1;
      end
    end else begin
      if (e[6] == 1'b0 && m_stall < 64'h0000_0000_FFFF_FFFF) m_stall++;
      if (frz) m_wait = 1;
      else begin
        m_wait = 0;
        if (v.hlt) m_drain_left = DRAIN;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp,
                     input logic [31:0] mask);
    n_checks++;
    if (((act ^ exp) & mask) !== 32'h0) begin
      $display("FAIL %s: got %h want %h (mask %h)", name, act, exp, mask);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input vin_t v);
    nRST = v.rst_n; ihit = v.ihit; dhit = v.dhit; dREN_MEM = v.dren; dWEN_MEM = v.dwen;
    memtoReg_EX = v.m2r; RegWr_EX = v.rwr; wsel_EX = v.wsel; rs_ID = v.rs; rt_ID = v.rt;
    uses_rt_ID = v.uses_rt; branch_taken_EX = v.br; halt_EX = v.hlt;
  endtask

  // One cycle: drive at negedge, compare against the model, clock, advance model.
  task automatic step(input vin_t v, input string tag);
    logic [6:0] e, care;
    @(negedge CLK);
    drive(v);
    #1;
    model_out(v, e, care);
    chk({tag, "_ctrl"},  32'(act_ctrl), 32'(e), 32'(care));
    chk({tag, "_halt"},  32'(halt), 32'(m_halted), 32'h1);
    chk({tag, "_stall"}, stall_cycles, m_stall[31:0], 32'hFFFF_FFFF);
    @(posedge CLK);
    model_update(v, e);
    #1;
  endtask

  // Step plus a hand-derived expectation for the same cycle.
  task automatic step_exp(input vin_t v, input string tag, input logic [6:0] exp,
                          input logic [6:0] care);
    @(negedge CLK);
    drive(v);
    #1;
    chk({tag, "_fixed"}, 32'(act_ctrl), 32'(exp), 32'(care));
    @(posedge CLK);
    #1;
    // model still has to track the cycle; replay its view at negedge-equivalent
  endtask

  task automatic do_reset();
    vin_t v;
    v = idle();
    v.rst_n = 1'b0;
    step(v, "rst");
    step(v, "rst");
  endtask

  task automatic add(input string name, input vin_t v, input logic [6:0] exp,
                     input logic [6:0] care);
    tvec_t t;
    t.name = name; t.in = v; t.exp = exp; t.care = care;
    tbl.push_back(t);
  endtask

  initial begin
    vin_t v;
    logic [6:0] e, care;

    drive(idle());
    nRST = 1'b0;
    m_wait = 0; m_halted = 0; m_drain_left = 0; m_stall = 0;

    // ---- single-cycle vector table, applied in order from reset ----
    v = idle();                                              add("normal", v, E_RUN, C_ALL);
    v = idle(); v.m2r=1; v.rwr=1; v.wsel=2; v.rs=2; v.rt=4; v.uses_rt=1; add("lu_rs", v, E_LU, C_LU);
    v = idle(); v.m2r=1; v.rwr=1; v.wsel=4; v.rs=2; v.rt=4; v.uses_rt=1; add("lu_rt", v, E_LU, C_LU);
    v = idle(); v.m2r=1; v.rwr=1; v.wsel=4; v.rs=2; v.rt=4; v.uses_rt=0; add("rt_unused", v, E_RUN, C_ALL);
    v = idle(); v.m2r=1; v.rwr=1; v.wsel=0; v.rs=0; v.rt=0; v.uses_rt=1; add("lu_r0", v, E_RUN, C_ALL);
    v = idle(); v.m2r=1; v.rwr=0; v.wsel=3; v.rs=3;                      add("no_regwr", v, E_RUN, C_ALL);
    v = idle(); v.ihit=0;                                                add("imiss", v, E_IM, C_IM);
    v = idle(); v.ihit=0; v.br=1; v.m2r=1; v.rwr=1; v.wsel=5; v.rs=5;    add("br_lu_im", v, E_SQ, C_ALL);
    v = idle(); v.dren=1; v.br=1;                                        add("dmiss_br", v, E_FRZ, C_ALL);
    v = idle(); v.dren=1; v.dhit=1; v.br=1;                              add("wait_hit_br", v, E_SQ, C_ALL);
    v = idle(); v.dwen=1; v.dhit=1;                                      add("dwen_hit", v, E_RUN, C_ALL);
    v = idle(); v.dren=1;                                                add("dmiss", v, E_FRZ, C_ALL);
    v = idle();                                                          add("wait_nohit", v, E_FRZ, C_ALL);
    v = idle(); v.dhit=1; v.m2r=1; v.rwr=1; v.wsel=7; v.rs=7;            add("wait_hit_lu", v, E_LU, C_LU);

    do_reset();
    foreach (tbl[i]) begin
      @(negedge CLK);
      drive(tbl[i].in);
      #1;
      chk(tbl[i].name, 32'(act_ctrl), 32'(tbl[i].exp), 32'(tbl[i].care));
      model_out(tbl[i].in, e, care);
      @(posedge CLK);
      model_update(tbl[i].in, e);
      #1;
    end

    // ---- load-use: one bubble then normal, one stall cycle counted ----
    do_reset();
    v = idle(); v.m2r=1; v.rwr=1; v.wsel=2; v.rs=2; v.rt=4; v.uses_rt=1;
    step(v, "lu_seq");
    chk("lu_seq_cnt", stall_cycles, 32'd1, 32'hFFFF_FFFF);
    step(idle(), "lu_after");
    chk("lu_after_cnt", stall_cycles, 32'd1, 32'hFFFF_FFFF);

    // ---- data miss for 3 cycles then full advance ----
    do_reset();
    v = idle(); v.dren=1;
    for (int i = 0; i < 3; i++) step(v, "dmiss_seq");
    v.dhit = 1;
    @(negedge CLK); drive(v); #1;
    chk("dmiss_release", 32'(act_ctrl), 32'(E_RUN), 32'(C_ALL));
    model_out(v, e, care);
    @(posedge CLK); model_update(v, e); #1;
    chk("dmiss_cnt", stall_cycles, 32'd3, 32'hFFFF_FFFF);

    // ---- branch + load-use + imiss: squash, no stall counted ----
    do_reset();
    v = idle(); v.ihit=0; v.br=1; v.m2r=1; v.rwr=1; v.wsel=9; v.rt=9; v.uses_rt=1;
    step(v, "br_combo");
    chk("br_combo_cnt", stall_cycles, 32'd0, 32'hFFFF_FFFF);

    // ---- halt drain, no misses: halt rises on the 3rd edge ----
    do_reset();
    v = idle(); v.hlt = 1;
    step(v, "halt_in");
    step(idle(), "drain1");
    chk("halt_edge2", 32'(halt), 32'd0, 32'h1);
    step(idle(), "drain2");
    chk("halt_edge3", 32'(halt), 32'd1, 32'h1);
    step(idle(), "halted");

    // ---- halt drain with one dmiss cycle: halt one edge later ----
    do_reset();
    v = idle(); v.hlt = 1;
    step(v, "halt_in_m");
    v = idle(); v.dren = 1;
    step(v, "drain_miss");
    step(idle(), "drain_m1");
    chk("halt_m_edge3", 32'(halt), 32'd0, 32'h1);
    step(idle(), "drain_m2");
    chk("halt_m_edge4", 32'(halt), 32'd1, 32'h1);

    // ---- reset asserted mid-drain ----
    do_reset();
    v = idle(); v.ihit = 0;
    step(v, "pre_im");
    step(v, "pre_im");
    v = idle(); v.hlt = 1;
    step(v, "halt_in_r");
    step(idle(), "drain_r");
    v = idle(); v.rst_n = 0; v.hlt = 1; v.br = 1;
    @(negedge CLK); drive(v); #1;
    chk("rst_hold_ctrl", 32'(act_ctrl), 32'(E_RST), 32'(C_ALL));
    model_out(v, e, care);
    @(posedge CLK); model_update(v, e); #1;
    chk("rst_halt", 32'(halt), 32'd0, 32'h1);
    chk("rst_cnt", stall_cycles, 32'd0, 32'hFFFF_FFFF);
    step(v, "rst_hold2");
    @(negedge CLK); drive(idle()); #1;
    chk("rst_run_ctrl", 32'(act_ctrl), 32'(E_RUN), 32'(C_ALL));
    model_out(idle(), e, care);
    @(posedge CLK); model_update(idle(), e); #1;

    // ---- random stimulus against the model ----
    for (int n = 0; n < 1500; n++) begin
      v.rst_n   = ($urandom_range(63) != 0);
      v.ihit    = ($urandom_range(3) != 0);
      v.dhit    = $urandom_range(1) == 1;
      v.dren    = ($urandom_range(3) == 0);
      v.dwen    = ($urandom_range(5) == 0);
      v.m2r     = $urandom_range(1) == 1;
      v.rwr     = ($urandom_range(3) != 0);
      v.wsel    = 5'($urandom_range(3));
      v.rs      = 5'($urandom_range(3));
      v.rt      = 5'($urandom_range(3));
      v.uses_rt = $urandom_range(1) == 1;
      v.br      = ($urandom_range(5) == 0);
      v.hlt     = ($urandom_range(39) == 0);
      step(v, "rand");
    end

    // ---- saturation from a preloaded near-max count ----
    do_reset();
    step(idle(), "pre_sat");
    force dut.stall_cycles_q = 32'hFFFF_FF00;
    #1;
    release dut.stall_cycles_q;
    m_stall = 64'h0000_0000_FFFF_FF00;
    v = idle(); v.ihit = 0;
    for (int i = 0; i < 300; i++) step(v, "sat");
    chk("sat_final", stall_cycles, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline sequencing controller for the 5-stage MIPS core: generates the enable/flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. It resolves load-use stalls, taken-branch/jump squashes, instruction- and data-memory wait states, and halt drain. It also keeps a stall-cycle performance counter. It sits beside the pipeline registers in the datapath top level, and its outputs drive their `enable`/`flush` inputs directly.

## Interface
- `DRAIN_CYCLES`, default 2: cycles to retire EX/MEM and MEM/WB after a halt reaches EX.
- `CLK` in, 1: clock, rising edge.
- `nRST` in, 1: reset, synchronous, active-low.
- `ihit` in, 1: instruction memory returned the fetch this cycle.
- `dhit` in, 1: data memory completed the MEM-stage access this cycle.
- `dREN_MEM`, `dWEN_MEM` in, 1 each: MEM stage has a data read/write in flight.
- `memtoReg_EX`, `RegWr_EX` in, 1 each: EX-stage instruction is a load / writes a register.
- `wsel_EX` in, 5 (`regbits_t`): EX-stage destination register.
- `rs_ID`, `rt_ID` in, 5 (`regbits_t`): ID-stage source registers.
- `uses_rt_ID` in, 1: ID-stage instruction reads rt.
- `branch_taken_EX` in, 1: EX resolved a taken branch or jump (PC redirect).
- `halt_EX` in, 1: halt instruction in EX.
- `pc_en` out, 1: PC may update.
- `ifid_en`, `ifid_flush` out, 1 each: IF/ID register controls.
- `idex_en`, `idex_flush` out, 1 each: ID/EX register controls.
- `exmem_en`, `memwb_en` out, 1 each: EX/MEM and MEM/WB register controls.
- `halt` out, 1: core halted; registered.
- `stall_cycles` out, 32 (`word_t`): count of cycles with `pc_en`=0 outside DRAIN/HALTED.

## Operation
- FSM states (`hazard_state_t`): RUN, MEM_WAIT, DRAIN, HALTED.
- In RUN, evaluate in this priority order; the first match applies:
  1. `dmiss` = (`dREN_MEM`|`dWEN_MEM`) & !`dhit`: all enables 0 and all flushes 0 (freeze). Next state MEM_WAIT.
  2. `halt_EX`: `pc_en`=0, `ifid_flush`=`idex_flush`=1, `exmem_en`=`memwb_en`=1. Load drain_cnt=`DRAIN_CYCLES`. Next state DRAIN.
  3. `branch_taken_EX`: `pc_en`=1, `ifid_flush`=`idex_flush`=1, all enables 1. This overrides load-use and !`ihit`.
  4. Load-use: `memtoReg_EX` & `RegWr_EX` & `wsel_EX`≠0 & (`wsel_EX`==`rs_ID` | (`uses_rt_ID` & `wsel_EX`==`rt_ID`)). Outputs: `pc_en`=0, `ifid_en`=0, `idex_flush`=1, `exmem_en`=`memwb_en`=1.
  5. !`ihit`: `pc_en`=0, `ifid_flush`=1, all other enables 1.
  6. Otherwise all enables 1 and all flushes 0.
- MEM_WAIT:
  - While `dhit`=0: freeze, exactly as rule 1.
  - When `dhit`=1: apply RUN rules 2–6 in the same cycle, and take the next state from those rules (RUN, or DRAIN if rule 2 fires).
- DRAIN:
  - Outputs: `pc_en`=0, `ifid_flush`=`idex_flush`=1, `exmem_en`=`memwb_en`=1.
  - If `dmiss`, freeze all stages and hold drain_cnt.
  - Otherwise decrement drain_cnt. When drain_cnt reaches 1 and decrements, move to HALTED.
- HALTED: all enables 0, flushes 0, `halt`=1. Stays here until reset.
- `stall_cycles`: increments on every cycle where `pc_en`=0 and state is RUN or MEM_WAIT. Saturates at 0xFFFFFFFF.
- Any flush takes precedence over the enable of the same register.

## Timing
- Control outputs are Mealy: combinational from the registered state and the current inputs, so they apply in the same cycle as the hazard (zero latency).
- `halt` is registered; it rises on the first clock edge that enters HALTED.
- Load-use costs exactly one bubble: on the next cycle the load is in MEM and the hazard condition clears.
- Reset (`nRST`=0 at the edge) has the highest priority:
  - state := RUN, drain_cnt := 0, `stall_cycles` := 0, `halt` := 0.
  - While `nRST`=0: all enables 0 and all flushes 1.
  - Reset in any state, including mid-DRAIN or mid-MEM_WAIT, returns to RUN with no residue.
- Simultaneous events resolve by the priority list above, e.g. `dmiss` + `branch_taken_EX` = freeze; the branch applies on the `dhit` cycle.

## Structure
- `hazard_state_t` enum goes in `cpu_types_pkg`.
- `regbits_t` and `word_t` are already in `cpu_types_pkg` and are reused.
- The load-use comparator is one combinational sub-module, `load_use_detect`. It takes the EX/ID fields and outputs `lu_hazard`.
- The FSM, drain counter and stall counter live in `hazard_unit`.

## Test plan
- Load-use: `lw $2` in EX, `add $3,$2,$4` in ID, `ihit`=1 → one cycle with `pc_en`=0, `ifid_en`=0, `idex_flush`=1; normal the next cycle; `stall_cycles`=1. With `wsel_EX`=0 → no stall.
- Data miss: `dREN_MEM`=1, `dhit`=0 for 3 cycles, then 1 → 3 cycles with all enables 0, then a full advance; `stall_cycles`=3.
- Branch + load-use + !`ihit` in the same cycle → `pc_en`=1, `ifid_flush`=`idex_flush`=1; `stall_cycles` unchanged.
- Halt with `DRAIN_CYCLES`=2, no misses → DRAIN for 2 cycles, `halt`=1 on the 3rd edge. With one `dmiss` cycle during DRAIN → `halt` is one cycle later.
- `nRST`=0 asserted mid-DRAIN → next cycle: RUN, `halt`=0, `stall_cycles`=0. While `nRST` is held low: all flushes 1.
- 300 consecutive !`ihit` cycles with a preloaded near-max count → `stall_cycles` saturates at 0xFFFFFFFF.
